reg_bank: RTL and testbench

Parametrised register bank that generalises the lab single 16-bit load register. It holds DEPTH words of WIDTH bits, and each clock one addressed word can be loaded, cleared, incremented, decremented or shifted. Two independent read ports and a carry/shift-out flag are provided. It sits between the datapath ALU and the control FSM, as the general-purpose register storage for later labs.

---
 rtl/reg_bank.sv | 115 +++++++++++
 tb/tb_reg_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// General-purpose register bank: DEPTH x WIDTH words with per-cycle
// load/clear/inc/dec/shift on one addressed word and two async read ports.
module reg_bank #(
    parameter int               WIDTH     = 16,
    parameter int               ADDR_W    = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  din,
    input  logic              sin,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  dout_a,
    output logic [WIDTH-1:0]  dout_b,
    output logic              zero_a,
    output logic              carry
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_LOAD      = 3'b001,
        OP_CLEAR     = 3'b010,
        OP_INC       = 3'b011,
        OP_DEC       = 3'b100,
        OP_SHL       = 3'b101,
        OP_SHR       = 3'b110,
        OP_CLEAR_ALL = 3'b111
    } op_e;

    op_e              op_sel;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             nxt_carry;
    logic             wr;

    assign op_sel = op_e'(op);

    // Next value and flag for the addressed word only.
    always_comb begin
        cur       = regs[waddr];
        nxt       = cur;
        nxt_carry = carry;
        wr        = 1'b0;
        unique case (op_sel)
            OP_NOP: begin
                nxt_carry = carry;
            end
            OP_LOAD: begin
                nxt       = din;
                nxt_carry = 1'b0;
                wr        = 1'b1;
            end
            OP_CLEAR: begin
                nxt       = '0;
                nxt_carry = 1'b0;
                wr        = 1'b1;
            end
            OP_INC: begin
                nxt       = cur + ONE;
                nxt_carry = &cur;
                wr        = 1'b1;
            end
            OP_DEC: begin
                nxt       = cur - ONE;
                nxt_carry = ~|cur;
                wr        = 1'b1;
            end
            OP_SHL: begin
                nxt       = {cur[WIDTH-2:0], sin};
                nxt_carry = cur[WIDTH-1];
                wr        = 1'b1;
            end
            OP_SHR: begin
                nxt       = {sin, cur[WIDTH-1:1]};
                nxt_carry = cur[0];
                wr        = 1'b1;
            end
            OP_CLEAR_ALL: begin
                nxt_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL;
            end
            carry <= 1'b0;
        end else begin
            carry <= nxt_carry;
            if (op_sel == OP_CLEAR_ALL) begin
                for (int i = 0; i < DEPTH; i++) begin
                    regs[i] <= RESET_VAL;
                end
            end else if (wr) begin
                regs[waddr] <= nxt;
            end
        end
    end

    // No write bypass: reads always see the stored value.
    assign dout_a = regs[raddr_a];
    assign dout_b = regs[raddr_b];
    assign zero_a = ~|dout_a;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: two instances (RESET_VAL 0 and 5)
// share stimulus; a reference model pushes expectations to a queue.
module tb_reg_bank;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] CLR  = 3'b010;
    localparam logic [2:0] INC  = 3'b011;
    localparam logic [2:0] DEC  = 3'b100;
    localparam logic [2:0] SHL  = 3'b101;
    localparam logic [2:0] SHR  = 3'b110;
    localparam logic [2:0] CLRA = 3'b111;

    logic        clk;
    logic        reset;
    logic [2:0]  op;
    logic [2:0]  waddr;
    logic [15:0] din;
    logic        sin;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic        zero_a0, carry0, zero_a1, carry1;

    reg_bank #(.WIDTH(16), .ADDR_W(3), .RESET_VAL(16'h0000)) u0 (
        .clk(clk), .reset(reset), .op(op), .waddr(waddr), .din(din),
        .sin(sin), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .dout_a(dout_a0), .dout_b(dout_b0), .zero_a(zero_a0),
        .carry(carry0)
    );

    reg_bank #(.WIDTH(16), .ADDR_W(3), .RESET_VAL(16'h0005)) u1 (
        .clk(clk), .reset(reset), .op(op), .waddr(waddr), .din(din),
        .sin(sin), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .dout_a(dout_a1), .dout_b(dout_b1), .zero_a(zero_a1),
        .carry(carry1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        z;
        logic        c;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m [2][8];
    logic        mc [2];
    logic [15:0] rv [2];
    int          vectors;
    int          miscompares;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 8; r++) m[i][r] = rv[i];
            mc[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [2:0] o, input logic [2:0] wa,
                              input logic [15:0] d, input logic s);
        logic [15:0] old;
        for (int i = 0; i < 2; i++) begin
            old = m[i][wa];
            case (o)
                LOAD: begin m[i][wa] = d; mc[i] = 1'b0; end
                CLR:  begin m[i][wa] = 16'h0000; mc[i] = 1'b0; end
                INC:  begin m[i][wa] = old + 16'd1; mc[i] = (old == 16'hFFFF); end
                DEC:  begin m[i][wa] = old - 16'd1; mc[i] = (old == 16'h0000); end
                SHL:  begin m[i][wa] = {old[14:0], s}; mc[i] = old[15]; end
                SHR:  begin m[i][wa] = {s, old[15:1]}; mc[i] = old[0]; end
                CLRA: begin
                    for (int r = 0; r < 8; r++) m[i][r] = rv[i];
                    mc[i] = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic push_exp(input logic [2:0] ra, input logic [2:0] rb);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e.a = m[i][ra];
            e.b = m[i][rb];
            e.z = (m[i][ra] == 16'h0000);
            e.c = mc[i];
            sb.push_back(e);
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() < 2) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd2);
            return;
        end
        e = sb.pop_front();
        check({tag, "_a0"}, 32'(dout_a0), 32'(e.a));
        check({tag, "_b0"}, 32'(dout_b0), 32'(e.b));
        check({tag, "_z0"}, 32'(zero_a0), 32'(e.z));
        check({tag, "_c0"}, 32'(carry0), 32'(e.c));
        e = sb.pop_front();
        check({tag, "_a1"}, 32'(dout_a1), 32'(e.a));
        check({tag, "_b1"}, 32'(dout_b1), 32'(e.b));
        check({tag, "_z1"}, 32'(zero_a1), 32'(e.z));
        check({tag, "_c1"}, 32'(carry1), 32'(e.c));
    endtask

    // Drive at negedge, check old contents before the edge, new after it.
    task automatic do_op(input string tag, input logic [2:0] o,
                         input logic [2:0] wa, input logic [15:0] d,
                         input logic s, input logic [2:0] ra,
                         input logic [2:0] rb);
        @(negedge clk);
        op = o; waddr = wa; din = d; sin = s;
        raddr_a = ra; raddr_b = rb;
        #1;
        push_exp(ra, rb);
        pop_cmp({tag, "_pre"});
        model_step(o, wa, d, s);
        push_exp(ra, rb);
        @(posedge clk);
        #1;
        pop_cmp({tag, "_post"});
    endtask

    task automatic sweep(input string tag);
        for (int r = 0; r < 8; r++) begin
            do_op(tag, NOP, 3'd0, 16'h0, 1'b0, 3'(r), 3'(7 - r));
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rv[0] = 16'h0000;
        rv[1] = 16'h0005;
        reset = 1'b1;
        op = NOP; waddr = 0; din = 0; sin = 0;
        raddr_a = 0; raddr_b = 7;
        #1 reset = 1'b0;
        model_reset();
        #2;
        push_exp(3'd0, 3'd7);
        pop_cmp("rst");
        op = INC; waddr = 3'd0;
        @(posedge clk);
        #1;
        push_exp(3'd0, 3'd7);
        pop_cmp("rst_hold");
        @(negedge clk);
        op = NOP;
        reset = 1'b1;

        do_op("ld3", LOAD, 3'd3, 16'h1234, 1'b0, 3'd3, 3'd5);
        do_op("ld5", LOAD, 3'd5, 16'hBEEF, 1'b0, 3'd3, 3'd5);
        sweep("sweep1");

        do_op("ldff", LOAD, 3'd1, 16'hFFFF, 1'b0, 3'd1, 3'd3);
        do_op("inc_wrap", INC, 3'd1, 16'h0, 1'b0, 3'd1, 3'd3);
        do_op("nop_hold", NOP, 3'd1, 16'h0, 1'b0, 3'd1, 3'd3);
        do_op("inc_1", INC, 3'd1, 16'h0, 1'b0, 3'd1, 3'd3);

        do_op("clr2", CLR, 3'd2, 16'h0, 1'b0, 3'd2, 3'd5);
        do_op("dec_wrap", DEC, 3'd2, 16'h0, 1'b0, 3'd2, 3'd5);

        do_op("ld8001", LOAD, 3'd0, 16'h8001, 1'b0, 3'd0, 3'd2);
        do_op("shl", SHL, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2);
        do_op("shr", SHR, 3'd0, 16'h0, 1'b1, 3'd0, 3'd2);

        do_op("rdw", LOAD, 3'd4, 16'h00AA, 1'b0, 3'd4, 3'd4);
        do_op("clr_all", CLRA, 3'd4, 16'h0, 1'b0, 3'd4, 3'd5);
        sweep("sweep2");

        do_op("inc6a", INC, 3'd6, 16'h0, 1'b0, 3'd6, 3'd1);
        do_op("inc6b", INC, 3'd6, 16'h0, 1'b0, 3'd6, 3'd1);
        do_op("inc6c", INC, 3'd6, 16'h0, 1'b0, 3'd6, 3'd1);
        @(negedge clk);
        op = INC; waddr = 3'd6;
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        push_exp(3'd6, 3'd1);
        pop_cmp("async_rst");
        @(negedge clk);
        reset = 1'b1;
        op = NOP;
        do_op("inc6_resume", INC, 3'd6, 16'h0, 1'b0, 3'd6, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
